// File: rtl/alu_issue.sv
// Purpose: RV32I ALU issue stage; decodes operands/control into a two-entry skid buffer (ALU_ISSUE_ILLEGAL_EN adds illegal-encoding detection).
// Latency: one cycle from accept to out_valid when empty.
// Backpressure: in_ready drops only when both entries are full; outputs hold steady while out_ready is low.
module alu_issue (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_in1,
   output logic [31:0] out_in2,
   output logic [3:0]  out_control,
   output logic [4:0]  out_rd,
   output logic        out_is_branch,
   output logic        out_illegal
);

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        is_branch;
      logic        illegal;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] CTRL_ADD  = 4'b0000;
   localparam logic [3:0] CTRL_SLT  = 4'b0010;
   localparam logic [3:0] CTRL_SLTU = 4'b0011;
   localparam logic [3:0] CTRL_SUB  = 4'b1000;
   localparam logic [3:0] CTRL_INV  = 4'b1111;

   state_t      state, state_nxt;
   entry_t      dec, out_q, skid_q;
   logic        illegal_dec;
   logic        accept, consume;
   logic        load_out, load_skid, out_from_skid;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [31:0] imm_i, imm_s, imm_u;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign rd     = in_instr[11:7];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_u  = {in_instr[31:12], 12'h000};

`ifdef ALU_ISSUE_ILLEGAL_EN
   logic [6:0] funct7;
   assign funct7 = in_instr[31:25];

   // flag encodings outside the supported RV32I subset
   always_comb begin
      illegal_dec = 1'b0;
      case (opcode)
         OPC_OP:
            illegal_dec = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
         OPC_OPIMM:
            illegal_dec = ((funct3 == 3'b001) || (funct3 == 3'b101)) &&
                          !((funct7 == 7'h00) || (funct7 == 7'h20));
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH:
            illegal_dec = 1'b0;
         default:
            illegal_dec = 1'b1;
      endcase
   end
`else
   assign illegal_dec = 1'b0;
`endif

   // decode the offered instruction into ALU operands and control
   always_comb begin
      dec      = '0;
      dec.in1  = in_rs1;
      dec.ctrl = CTRL_ADD;
      case (opcode)
         OPC_OP: begin
            dec.in2  = in_rs2;
            dec.ctrl = {in_instr[30], funct3};
            dec.rd   = rd;
         end
         OPC_OPIMM: begin
            // only SRAI uses bit 30 as an opcode bit; ADDI with imm[10]=1 stays add
            dec.in2  = imm_i;
            dec.ctrl = {in_instr[30] & (funct3 == 3'b101), funct3};
            dec.rd   = rd;
         end
         OPC_LUI: begin
            dec.in1 = '0;
            dec.in2 = imm_u;
            dec.rd  = rd;
         end
         OPC_AUIPC: begin
            dec.in1 = in_pc;
            dec.in2 = imm_u;
            dec.rd  = rd;
         end
         OPC_JAL, OPC_JALR: begin
            dec.in1 = in_pc;
            dec.in2 = 32'd4;
            dec.rd  = rd;
         end
         OPC_LOAD: begin
            dec.in2 = imm_i;
            dec.rd  = rd;
         end
         OPC_STORE: begin
            dec.in2 = imm_s;
         end
         OPC_BRANCH: begin
            dec.in2       = in_rs2;
            dec.is_branch = 1'b1;
            case (funct3[2:1])
               2'b10:   dec.ctrl = CTRL_SLT;
               2'b11:   dec.ctrl = CTRL_SLTU;
               default: dec.ctrl = CTRL_SUB;
            endcase
         end
         default: begin
            // unknown opcode: harmless add of rs1 with zero, no writeback
         end
      endcase
      if (illegal_dec) begin
         dec.illegal = 1'b1;
         dec.ctrl    = CTRL_INV;
         dec.rd      = '0;
      end
   end

   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   // skid-buffer state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= EMPTY;
      else          state <= state_nxt;
   end

   // next state and buffer load enables
   always_comb begin
      state_nxt     = state;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_out  = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  load_out = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_nxt = TWO;
               end else if (consume) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (consume) begin
                  load_out      = 1'b1;
                  out_from_skid = 1'b1;
                  state_nxt     = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // output and skid data registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
         if (load_skid) skid_q <= dec;
      end
   end

   assign out_in1       = out_q.in1;
   assign out_in2       = out_q.in2;
   assign out_control   = out_q.ctrl;
   assign out_rd        = out_q.rd;
   assign out_is_branch = out_q.is_branch;
   assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed decode vectors, backpressure/flush/reset cases, then random traffic
// against a queue-based reference of the buffer contents.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
   logic [31:0] out_in1, out_in2;
   logic [3:0]  out_control;
   logic [4:0]  out_rd;
   logic        out_is_branch, out_illegal;

   alu_issue dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_in1(out_in1), .out_in2(out_in2), .out_control(out_control),
      .out_rd(out_rd), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

`ifdef ALU_ISSUE_ILLEGAL_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        br;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;

   // reference decode: straight from the instruction-class rules
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int f3, iv, sv;
      int br_tab[8];
      logic [6:0] f7;
      logic signed [11:0] si, ss;
      bit known, bad;
      br_tab = '{8, 8, 8, 8, 2, 2, 3, 3};
      f3 = int'(ins[14:12]);
      f7 = ins[31:25];
      si = ins[31:20];
      ss = {ins[31:25], ins[11:7]};
      iv = si;
      sv = ss;
      known = 1'b1;
      bad   = 1'b0;
      e = '0;
      e.in1 = a;
      case (ins[6:0])
         7'h33: begin
            e.in2 = b; e.rd = ins[11:7]; e.ctrl = 4'(f3 + (ins[30] ? 8 : 0));
            bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
         end
         7'h13: begin
            e.in2 = iv; e.rd = ins[11:7]; e.ctrl = 4'(f3 + ((f3 == 5 && ins[30]) ? 8 : 0));
            bad = (f3 == 1 || f3 == 5) && !(f7 == 7'h00 || f7 == 7'h20);
         end
         7'h37: begin e.in1 = 0;  e.in2 = {ins[31:12], 12'h0}; e.rd = ins[11:7]; end
         7'h17: begin e.in1 = pc; e.in2 = {ins[31:12], 12'h0}; e.rd = ins[11:7]; end
         7'h6F, 7'h67: begin e.in1 = pc; e.in2 = 4; e.rd = ins[11:7]; end
         7'h03: begin e.in2 = iv; e.rd = ins[11:7]; end
         7'h23: begin e.in2 = sv; end
         7'h63: begin e.in2 = b; e.br = 1'b1; e.ctrl = 4'(br_tab[f3]); end
         default: known = 1'b0;
      endcase
      e.ill = ILL_EN & (!known || bad);
      if (e.ill) begin
         e.ctrl = 4'hF;
         e.rd   = 0;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      logic [6:0]  opcs[11];
      int sel;
      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h0B};
      w   = $urandom;
      sel = $urandom_range(0, 10);
      w[6:0] = opcs[sel];
      if (sel == 0) w[31:25] = w[31] ? 7'h20 : 7'h00;
      if (sel == 8 && w[14:13] == 2'b01) w[13] = 1'b0;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         chk("in1", out_in1, q[0].in1);
         chk("in2", out_in2, q[0].in2);
         chk("control", 32'(out_control), 32'(q[0].ctrl));
         chk("rd", 32'(out_rd), 32'(q[0].rd));
         chk("is_branch", 32'(out_is_branch), 32'(q[0].br));
         chk("illegal", 32'(out_illegal), 32'(q[0].ill));
      end
   endtask

   // drive one cycle of stimulus, advance the model, then check after the edge
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic rdy, input logic fl);
      int n;
      in_valid = v; in_instr = ins; in_pc = pc; in_rs1 = a; in_rs2 = b;
      out_ready = rdy; flush = fl;
      n = q.size();
      if (fl) begin
         q.delete();
      end else begin
         if (rdy && n > 0) void'(q.pop_front());
         if (v && n < 2) q.push_back(model(ins, pc, a, b));
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic reset_outputs_chk(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
      chk({tag, "_in1"}, out_in1, 0);
      chk({tag, "_in2"}, out_in2, 0);
      chk({tag, "_ctrl"}, 32'(out_control), 0);
      chk({tag, "_rd"}, 32'(out_rd), 0);
      chk({tag, "_br_ill"}, 32'({out_is_branch, out_illegal}), 0);
   endtask

   initial begin
      logic [31:0] ia, ib, ic;
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
      #2;
      reset_outputs_chk("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // ADD x3,x1,x2
      cyc(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, 0);
      chk("add_valid", 32'(out_valid), 1);
      chk("add_in1", out_in1, 5);
      chk("add_in2", out_in2, 7);
      chk("add_ctrl", 32'(out_control), 0);
      chk("add_rd", 32'(out_rd), 3);
      // SRAI x5,x6,4
      cyc(1, 32'h40435293, 32'h0, 32'h80000000, $urandom, 1, 0);
      chk("srai_ctrl", 32'(out_control), 32'hD);
      chk("srai_in2", out_in2, 32'h404);
      // ADDI x1,x0,-1
      cyc(1, 32'hFFF00093, 32'h0, 32'h0, $urandom, 1, 0);
      chk("addi_in2", out_in2, 32'hFFFFFFFF);
      chk("addi_ctrl", 32'(out_control), 0);
      // BLTU x1,x2
      cyc(1, 32'h0020E463, 32'h40, $urandom, $urandom, 1, 0);
      chk("bltu_ctrl", 32'(out_control), 3);
      chk("bltu_br", 32'(out_is_branch), 1);
      chk("bltu_rd", 32'(out_rd), 0);
      // JAL x1 at 0x100
      cyc(1, 32'h000000EF, 32'h100, $urandom, $urandom, 1, 0);
      chk("jal_in1", out_in1, 32'h100);
      chk("jal_in2", out_in2, 4);
      chk("jal_rd", 32'(out_rd), 1);
      // all-ones word
      cyc(1, 32'hFFFFFFFF, 32'h0, 32'h1234, 32'h5678, 1, 0);
      chk("ones_ill", 32'(out_illegal), ILL_EN ? 1 : 0);
      chk("ones_ctrl", 32'(out_control), ILL_EN ? 32'hF : 0);
      if (!ILL_EN) chk("ones_in2", out_in2, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);

      // backpressure: A,B accepted, C held, then drained in order
      ia = 32'h002081B3; ib = 32'h40208233; ic = 32'h0020F2B3;
      cyc(1, ia, 0, 32'd11, 32'd1, 0, 0);
      cyc(1, ib, 0, 32'd22, 32'd2, 0, 0);
      chk("two_in_ready", 32'(in_ready), 0);
      cyc(1, ic, 0, 32'd33, 32'd3, 0, 0);
      cyc(1, ic, 0, 32'd33, 32'd3, 0, 0);
      chk("hold_in1", out_in1, 11);
      cyc(1, ic, 0, 32'd33, 32'd3, 1, 0);
      chk("order_b", out_in1, 22);
      cyc(1, ic, 0, 32'd33, 32'd3, 1, 0);
      chk("order_c", out_in1, 33);
      cyc(0, 0, 0, 0, 0, 1, 0);

      // flush while full, with a simultaneous offer
      cyc(1, ia, 0, 1, 2, 0, 0);
      cyc(1, ib, 0, 3, 4, 0, 0);
      cyc(1, ic, 0, 5, 6, 0, 1);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_ready", 32'(in_ready), 1);

      // asynchronous reset pulse while full
      cyc(1, ia, 0, 1, 2, 0, 0);
      cyc(1, ib, 0, 3, 4, 0, 0);
      in_valid = 1'b0; out_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      reset_outputs_chk("midreset");
      q.delete();
      #2;
      reset_n = 1'b1;
      cyc(1, ic, 0, 7, 8, 0, 0);
      chk("after_reset_in1", out_in1, 7);
      cyc(0, 0, 0, 0, 0, 1, 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
